// File: rtl/gelato_warp_issue_arbiter_pkg.sv
// Shared types for the warp issue arbiter: selection policy and issue FSM states.
// Parameter-dependent index types live in the modules that own the parameters.
package gelato_warp_issue_arbiter_pkg;

  typedef enum logic {
    PolicyRr  = 1'b0,
    PolicyGto = 1'b1
  } warp_sel_policy_e;

  typedef enum logic {
    StEmpty = 1'b0,
    StHold  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/gelato_warp_issue_arbiter_if.sv
// Instruction-buffer, scoreboard and issue-handshake bundle of the warp issue arbiter.
// master = arbiter side, slave = buffers / scoreboard / operand collector side.
interface gelato_warp_issue_arbiter_if #(
  parameter int unsigned WARP_NUM = 4,
  parameter int unsigned SB_SIZE  = 4,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned INST_W   = 64
);
  localparam int unsigned WarpW = $clog2(WARP_NUM);

  logic [WARP_NUM-1:0]              ibuf_valid;
  logic [WARP_NUM*INST_W-1:0]       ibuf_inst;
  logic [WARP_NUM*REG_W-1:0]        ibuf_rd;
  logic [WARP_NUM*REG_W-1:0]        ibuf_rs1;
  logic [WARP_NUM*REG_W-1:0]        ibuf_rs2;
  logic [WARP_NUM-1:0]              ibuf_pop;
  logic [WARP_NUM*SB_SIZE*REG_W-1:0] sb_regs;
  logic                             sb_alloc_valid;
  logic [WarpW-1:0]                 sb_alloc_warp;
  logic [REG_W-1:0]                 sb_alloc_reg;
  logic                             iss_valid;
  logic                             iss_ready;
  logic [INST_W-1:0]                iss_inst;
  logic [WarpW-1:0]                 iss_warp;

  modport master (
    input  ibuf_valid, ibuf_inst, ibuf_rd, ibuf_rs1, ibuf_rs2, sb_regs, iss_ready,
    output ibuf_pop, sb_alloc_valid, sb_alloc_warp, sb_alloc_reg, iss_valid, iss_inst, iss_warp
  );

  modport slave (
    output ibuf_valid, ibuf_inst, ibuf_rd, ibuf_rs1, ibuf_rs2, sb_regs, iss_ready,
    input  ibuf_pop, sb_alloc_valid, sb_alloc_warp, sb_alloc_reg, iss_valid, iss_inst, iss_warp
  );
endinterface

// File: rtl/gelato_warp_hazard_check.sv
// Per-warp scoreboard check: no RAW/WAW hit on nonzero registers and, when the head
// writes a register, at least one free scoreboard slot (a slot holding 0 is free).
module gelato_warp_hazard_check #(
  parameter int unsigned SB_SIZE = 4,
  parameter int unsigned REG_W   = 5
) (
  input  logic [REG_W-1:0]         rd,
  input  logic [REG_W-1:0]         rs1,
  input  logic [REG_W-1:0]         rs2,
  input  logic [SB_SIZE*REG_W-1:0] sb_regs,
  output logic                     ok
);

  logic             hit;
  logic             has_free;
  logic [REG_W-1:0] entry;

  always_comb begin
    hit      = 1'b0;
    has_free = 1'b0;
    entry    = '0;
    for (int unsigned s = 0; s < SB_SIZE; s++) begin
      entry = sb_regs[s*REG_W +: REG_W];
      if (entry == '0) begin
        has_free = 1'b1;
      end else if ((rs1 == entry) || (rs2 == entry) || (rd == entry)) begin
        hit = 1'b1;
      end
    end
    ok = !hit && ((rd == '0) || has_free);
  end

endmodule

// File: rtl/gelato_warp_issue_arbiter.sv
// Single-issue warp arbiter (round-robin / GTO) with a registered valid/ready issue slot.
// Define GELATO_WARPSKD_STATS_EN to add saturating issue/stall counters.
module gelato_warp_issue_arbiter
  import gelato_warp_issue_arbiter_pkg::*;
#(
  parameter int unsigned WARP_NUM = 4,
  parameter int unsigned SB_SIZE  = 4,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned INST_W   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       policy,
  gelato_warp_issue_arbiter_if.master arb
`ifdef GELATO_WARPSKD_STATS_EN
  ,
  output logic [31:0]                stat_issued,
  output logic [31:0]                stat_stall_hazard,
  output logic [31:0]                stat_stall_bp
`endif
);

  localparam int unsigned WarpW = $clog2(WARP_NUM);
  typedef logic [WarpW-1:0] warp_idx_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  arb_state_e          state_q;
  warp_idx_t           last_warp_q;
  logic                iss_valid_q;
  logic [INST_W-1:0]   iss_inst_q;
  warp_idx_t           iss_warp_q;
  reg_idx_t            iss_rd_q;
  logic [WARP_NUM-1:0] pop_q;
  logic                alloc_valid_q;
  warp_idx_t           alloc_warp_q;
  reg_idx_t            alloc_reg_q;

  logic [WARP_NUM-1:0] hz_ok;
  logic [WARP_NUM-1:0] elig;
  warp_sel_policy_e    pol;
  warp_idx_t           sel;
  warp_idx_t           cand;
  logic                found;
  logic                any_elig;

  for (genvar g = 0; g < WARP_NUM; g++) begin : g_hz
    gelato_warp_hazard_check #(
      .SB_SIZE (SB_SIZE),
      .REG_W   (REG_W)
    ) u_hz (
      .rd      (arb.ibuf_rd[g*REG_W +: REG_W]),
      .rs1     (arb.ibuf_rs1[g*REG_W +: REG_W]),
      .rs2     (arb.ibuf_rs2[g*REG_W +: REG_W]),
      .sb_regs (arb.sb_regs[g*SB_SIZE*REG_W +: SB_SIZE*REG_W]),
      .ok      (hz_ok[g])
    );
  end

  // The held warp is also the one accepted in a handshake cycle, so one term covers both.
  always_comb begin
    elig = '0;
    for (int unsigned w = 0; w < WARP_NUM; w++) begin
      elig[w] = arb.ibuf_valid[w] && hz_ok[w] &&
                !((state_q == StHold) && (warp_idx_t'(w) == iss_warp_q));
    end
  end

  assign pol      = warp_sel_policy_e'(policy);
  assign any_elig = |elig;

  always_comb begin
    sel   = last_warp_q;
    cand  = last_warp_q;
    found = 1'b0;
    if (pol == PolicyGto) begin
      if (elig[last_warp_q]) begin
        found = 1'b1;
      end
      for (int unsigned w = 0; w < WARP_NUM; w++) begin
        if (!found && elig[w]) begin
          sel   = warp_idx_t'(w);
          found = 1'b1;
        end
      end
    end else begin
      // Power-of-two warp count: index truncation gives the modulo wrap.
      for (int unsigned k = 1; k <= WARP_NUM; k++) begin
        cand = last_warp_q + warp_idx_t'(k);
        if (!found && elig[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StEmpty;
      last_warp_q   <= warp_idx_t'(WARP_NUM - 1);
      iss_valid_q   <= 1'b0;
      iss_inst_q    <= '0;
      iss_warp_q    <= '0;
      iss_rd_q      <= '0;
      pop_q         <= '0;
      alloc_valid_q <= 1'b0;
      alloc_warp_q  <= '0;
      alloc_reg_q   <= '0;
    end else if (rdy) begin
      pop_q         <= '0;
      alloc_valid_q <= 1'b0;
      unique case (state_q)
        StEmpty: begin
          if (any_elig) begin
            state_q     <= StHold;
            iss_valid_q <= 1'b1;
            iss_inst_q  <= arb.ibuf_inst[int'(sel)*INST_W +: INST_W];
            iss_warp_q  <= sel;
            iss_rd_q    <= arb.ibuf_rd[int'(sel)*REG_W +: REG_W];
          end
        end
        StHold: begin
          if (arb.iss_ready) begin
            pop_q[iss_warp_q] <= 1'b1;
            last_warp_q       <= iss_warp_q;
            if (iss_rd_q != '0) begin
              alloc_valid_q <= 1'b1;
              alloc_warp_q  <= iss_warp_q;
              alloc_reg_q   <= iss_rd_q;
            end
            if (any_elig) begin
              iss_inst_q <= arb.ibuf_inst[int'(sel)*INST_W +: INST_W];
              iss_warp_q <= sel;
              iss_rd_q   <= arb.ibuf_rd[int'(sel)*REG_W +: REG_W];
            end else begin
              state_q     <= StEmpty;
              iss_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  // Pulses stay pending while frozen and are masked until rdy returns.
  assign arb.ibuf_pop       = rdy ? pop_q : '0;
  assign arb.sb_alloc_valid = rdy & alloc_valid_q;
  assign arb.sb_alloc_warp  = alloc_warp_q;
  assign arb.sb_alloc_reg   = alloc_reg_q;
  assign arb.iss_valid      = iss_valid_q;
  assign arb.iss_inst       = iss_inst_q;
  assign arb.iss_warp       = iss_warp_q;

`ifdef GELATO_WARPSKD_STATS_EN
  logic [31:0] issued_q, stall_hz_q, stall_bp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q   <= '0;
      stall_hz_q <= '0;
      stall_bp_q <= '0;
    end else if (rdy) begin
      if (iss_valid_q && arb.iss_ready && (issued_q != '1)) begin
        issued_q <= issued_q + 32'd1;
      end
      if ((state_q == StEmpty) && (|arb.ibuf_valid) && !any_elig && (stall_hz_q != '1)) begin
        stall_hz_q <= stall_hz_q + 32'd1;
      end
      if (iss_valid_q && !arb.iss_ready && (stall_bp_q != '1)) begin
        stall_bp_q <= stall_bp_q + 32'd1;
      end
    end
  end

  assign stat_issued       = issued_q;
  assign stat_stall_hazard = stall_hz_q;
  assign stat_stall_bp     = stall_bp_q;
`endif

endmodule
